// File: rtl/nvm_snn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nvm_snn_pkg                                                     |
// | Brief    : Shared types and constants for the NVM synapse Wishbone master. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package nvm_snn_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_REQ   = 3'd2,
        S_RESP  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] C_ADDR_STEP = 32'h0000_0004;
    localparam logic [15:0] C_TMO_CYC   = 16'd1023;
    localparam logic [31:0] C_SYN_BASE  = 32'h3000_000C;
    localparam logic [3:0]  C_SEL_ALL   = 4'hF;

endpackage
`default_nettype wire

// File: rtl/nvm_wb_beat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nvm_wb_beat                                                     |
// | Brief    : One classic single Wishbone cycle; optional ack timeout via     |
// |            WB_TIMEOUT_EN.                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nvm_wb_beat
    import nvm_snn_pkg::*;
#(
    parameter logic [15:0] TMO_CYC = C_TMO_CYC
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       we_i,
    input  logic       wb_ack_i,
    output logic       cyc_o,
    output logic       we_o,
    output logic [3:0] sel_o,
    output logic       ack_o,
    output logic       tmo_o
);

    logic       cyc_q;
    logic       we_q;
    logic [3:0] sel_q;

    // An ack is only meaningful while our cycle is open, including its first clock.
    assign ack_o = cyc_q & wb_ack_i;

`ifdef WB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    assign tmo_o = cyc_q & ~wb_ack_i & (tmo_cnt_q == (TMO_CYC - 16'd1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= 16'd0;
        end else if (start_i) begin
            tmo_cnt_q <= 16'd0;
        end else if (cyc_q) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TMO_CYC;
    assign tmo_o        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= 4'h0;
        end else if (start_i) begin
            cyc_q <= 1'b1;
            we_q  <= we_i;
            sel_q <= C_SEL_ALL;
        end else if (ack_o || tmo_o) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= 4'h0;
        end
    end

    assign cyc_o = cyc_q;
    assign we_o  = we_q;
    assign sel_o = sel_q;

endmodule
`default_nettype wire

// File: rtl/nvm_synapse_wb_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nvm_synapse_wb_master                                           |
// | Brief    : Burst Wishbone initiator for the NVM synapse matrix; optional   |
// |            ack timeout via WB_TIMEOUT_EN.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nvm_synapse_wb_master
    import nvm_snn_pkg::*;
#(
    parameter int unsigned  LEN_W     = 8,
    parameter logic [31:0]  ADDR_STEP = C_ADDR_STEP,
    parameter logic [15:0]  TMO_CYC   = C_TMO_CYC
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdat_valid,
    output logic             wdat_ready,
    input  logic [31:0]      wdat,
    output logic             rdat_valid,
    input  logic             rdat_ready,
    output logic [31:0]      rdat,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdat_q;
    logic [31:0]      rdat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             cmd_ready_q;
    logic             done_q;
    logic             err_q;

    logic             w_cmd_hs;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_start;
    logic             w_beat_we;
    logic             w_beat_ack;
    logic             w_beat_tmo;
    logic             w_cyc;

    assign w_cmd_hs  = cmd_valid & cmd_ready_q;
    assign w_cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    if (cmd_len == '0)  state_d = S_DONE;
                    else if (cmd_write) state_d = S_FETCH;
                    else                state_d = S_REQ;
                end
            end
            S_FETCH: if (wdat_valid) state_d = S_REQ;
            S_REQ: begin
                if (w_beat_tmo)      state_d = S_DONE;
                else if (w_beat_ack) state_d = we_q ? S_NEXT : S_RESP;
            end
            S_RESP:  if (rdat_ready) state_d = S_NEXT;
            S_NEXT:  state_d = (w_cnt_inc == len_q) ? S_DONE : (we_q ? S_FETCH : S_REQ);
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Opening the bus cycle on the same edge that enters REQ keeps cyc aligned with the state.
    assign w_start   = (state_d == S_REQ) && (state_q != S_REQ);
    assign w_beat_we = (state_q == S_IDLE) ? cmd_write : we_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdat_q      <= 32'd0;
            rdat_q      <= 32'd0;
            len_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == S_IDLE);
            done_q      <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        we_q   <= cmd_write;
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                    end
                end
                S_FETCH: if (wdat_valid) wdat_q <= wdat;
                S_REQ: begin
                    if (w_beat_ack && !we_q) rdat_q <= wbm_dat_i;
                    if (w_beat_tmo)          err_q  <= 1'b1;
                end
                S_NEXT: begin
                    addr_q <= addr_q + ADDR_STEP;
                    cnt_q  <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    nvm_wb_beat #(
        .TMO_CYC (TMO_CYC)
    ) u_beat (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_n),
        .start_i  (w_start),
        .we_i     (w_beat_we),
        .wb_ack_i (wbm_ack_i),
        .cyc_o    (w_cyc),
        .we_o     (wbm_we_o),
        .sel_o    (wbm_sel_o),
        .ack_o    (w_beat_ack),
        .tmo_o    (w_beat_tmo)
    );

    assign cmd_ready  = cmd_ready_q;
    assign wdat_ready = (state_q == S_FETCH);
    assign rdat_valid = (state_q == S_RESP);
    assign rdat       = rdat_q;
    assign wbm_cyc_o  = w_cyc;
    assign wbm_stb_o  = w_cyc;
    assign wbm_adr_o  = addr_q;
    assign wbm_dat_o  = wdat_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nvm_synapse_wb_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_nvm_synapse_wb_master                                        |
// | Brief    : Directed self-checking bench; timeout case under WB_TIMEOUT_EN. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_nvm_synapse_wb_master;
    import nvm_snn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat;
    logic        rdat_valid, rdat_ready;
    logic [31:0] rdat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = 32'd0;
    logic        ack = 1'b0;
    logic        busy, done, err;

    always #5 clk = ~clk;

    nvm_synapse_wb_master #(
        .LEN_W     (8),
        .ADDR_STEP (32'h4),
        .TMO_CYC   (16'd8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .rdat_valid (rdat_valid),
        .rdat_ready (rdat_ready),
        .rdat       (rdat),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_dat_i  (dat_i),
        .wbm_ack_i  (ack),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Slave acks one cycle after it first sees stb; read data comes from rd_vals in order.
    logic        slave_en;
    logic [31:0] rd_vals [0:63];
    logic [31:0] wr_vals [0:63];
    int          rd_idx = 0;
    int          wr_idx = 0;

    assign wdat = wr_vals[wr_idx & 63];

    logic [31:0] log_adr [0:63];
    logic        log_we  [0:63];
    logic [31:0] log_dat [0:63];
    logic [31:0] rlog    [0:63];
    int          rise_t  [0:63];
    int          log_n = 0, rlog_n = 0, rise_n = 0, cyc_n = 0;
    int          cyc_hi = 0, done_n = 0, bus_bad = 0;
    logic        prev_cyc = 1'b0;

    always @(posedge clk) begin
        ack <= slave_en & cyc & stb & ~ack;
        if (slave_en && cyc && stb && !ack && !we) begin
            dat_i  <= rd_vals[rd_idx & 63];
            rd_idx <= rd_idx + 1;
        end
        if (wdat_valid && wdat_ready) wr_idx <= wr_idx + 1;
        cyc_n    <= cyc_n + 1;
        prev_cyc <= cyc;
        if (cyc && !prev_cyc) begin
            rise_t[rise_n & 63] <= cyc_n;
            rise_n              <= rise_n + 1;
        end
        if (cyc)  cyc_hi <= cyc_hi + 1;
        if (done) done_n <= done_n + 1;
        if ((stb !== cyc) || (sel !== (cyc ? 4'hF : 4'h0))) bus_bad <= bus_bad + 1;
        if (cyc && ack) begin
            log_adr[log_n & 63] <= adr;
            log_we[log_n & 63]  <= we;
            log_dat[log_n & 63] <= dat_o;
            log_n               <= log_n + 1;
        end
        if (rdat_valid && rdat_ready) begin
            rlog[rlog_n & 63] <= rdat;
            rlog_n            <= rlog_n + 1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
        int t = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 20) begin
            tick();
            t++;
        end
        check("cmd_ready_seen", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t = 0;
        while (!done && t < budget) begin
            tick();
            t++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    int b_log, b_rlog, b_rise, b_done, b_hi;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = 32'd0;
        cmd_len    = 8'd0;
        wdat_valid = 1'b0;
        rdat_ready = 1'b1;
        slave_en   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rd_vals[i] = 32'd0;
            wr_vals[i] = 32'd0;
        end
        repeat (3) tick();
        check("rst_ctrl", 32'({cyc, stb, we, sel, cmd_ready, busy, done, err, rdat_valid, wdat_ready}), 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat_o", dat_o, 32'd0);
        check("rst_rdat", rdat, 32'd0);
        rst_n      = 1'b1;
        wdat_valid = 1'b1;
        tick();
        tick();
        check("idle_ready", 32'(cmd_ready), 32'd1);

        // Write burst of three weights 1,0,1 into the synapse window.
        wr_vals[(wr_idx + 0) & 63] = 32'd1;
        wr_vals[(wr_idx + 1) & 63] = 32'd0;
        wr_vals[(wr_idx + 2) & 63] = 32'd1;
        b_log = log_n; b_rise = rise_n; b_done = done_n;
        send_cmd(1'b1, C_SYN_BASE, 8'd3);
        wait_done("wr_done", 100);
        tick();
        check("wr_done_pulse", 32'(done), 32'd0);
        check("wr_done_count", done_n - b_done, 32'd1);
        check("wr_beats", log_n - b_log, 32'd3);
        check("wr_adr0", log_adr[b_log & 63], 32'h3000_000C);
        check("wr_adr1", log_adr[(b_log + 1) & 63], 32'h3000_0010);
        check("wr_adr2", log_adr[(b_log + 2) & 63], 32'h3000_0014);
        check("wr_we", 32'({log_we[b_log & 63], log_we[(b_log + 1) & 63], log_we[(b_log + 2) & 63]}), 32'h7);
        check("wr_dat_bits", 32'({log_dat[b_log & 63][0], log_dat[(b_log + 1) & 63][0], log_dat[(b_log + 2) & 63][0]}), 32'h5);
        check("wr_beat_period", rise_t[(b_rise + 1) & 63] - rise_t[b_rise & 63], 32'd4);
        check("wr_err", 32'(err), 32'd0);
        check("wr_idle", 32'({busy, cmd_ready}), 32'h1);

        // Read burst of two words.
        rd_vals[(rd_idx + 0) & 63] = 32'h0000_0001;
        rd_vals[(rd_idx + 1) & 63] = 32'h0000_0000;
        b_log = log_n; b_rlog = rlog_n; b_rise = rise_n;
        send_cmd(1'b0, 32'h3000_0100, 8'd2);
        wait_done("rd_done", 100);
        check("rd_words", rlog_n - b_rlog, 32'd2);
        check("rd_word0", rlog[b_rlog & 63], 32'h0000_0001);
        check("rd_word1", rlog[(b_rlog + 1) & 63], 32'h0000_0000);
        check("rd_adr0", log_adr[b_log & 63], 32'h3000_0100);
        check("rd_adr1", log_adr[(b_log + 1) & 63], 32'h3000_0104);
        check("rd_we", 32'({log_we[b_log & 63], log_we[(b_log + 1) & 63]}), 32'h0);
        check("rd_beat_period", rise_t[(b_rise + 1) & 63] - rise_t[b_rise & 63], 32'd4);

        // Read with the downstream stalled for five cycles on the first word.
        rd_vals[(rd_idx + 0) & 63] = 32'hDEAD_0001;
        rd_vals[(rd_idx + 1) & 63] = 32'h0000_BEEF;
        b_rlog     = rlog_n;
        rdat_ready = 1'b0;
        send_cmd(1'b0, 32'h3000_0200, 8'd2);
        for (int t = 0; t < 20 && !rdat_valid; t++) tick();
        check("bp_valid", 32'(rdat_valid), 32'd1);
        b_rise = rise_n;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("bp_hold", {rdat_valid, cyc, rdat[29:0]}, {1'b1, 1'b0, 30'h1EAD_0001});
        end
        check("bp_no_cyc", rise_n - b_rise, 32'd0);
        rdat_ready = 1'b1;
        wait_done("bp_done", 100);
        check("bp_word0", rlog[b_rlog & 63], 32'hDEAD_0001);
        check("bp_word1", rlog[(b_rlog + 1) & 63], 32'h0000_BEEF);

        // Zero-length command: no bus cycle, busy only in DONE, done the cycle after.
        tick();
        b_rise = rise_n;
        check("len0_pre_busy", 32'(busy), 32'd0);
        send_cmd(1'b0, 32'h3000_0300, 8'd0);
        check("len0_in_done", 32'({busy, done, cyc}), 32'h4);
        tick();
        check("len0_done", 32'({busy, done, cyc}), 32'h2);
        check("len0_ready_again", 32'(cmd_ready), 32'd1);
        check("len0_no_cyc", rise_n - b_rise, 32'd0);

`ifdef WB_TIMEOUT_EN
        // Silent slave: cycle must be abandoned after eight clocks.
        slave_en = 1'b0;
        b_log = log_n; b_hi = cyc_hi; b_done = done_n;
        send_cmd(1'b0, C_SYN_BASE, 8'd3);
        wait_done("tmo_done", 100);
        check("tmo_cyc_len", cyc_hi - b_hi, 32'd8);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_no_beats", log_n - b_log, 32'd0);
        tick();
        check("tmo_one_done", done_n - b_done, 32'd1);
        slave_en = 1'b1;
        send_cmd(1'b1, C_SYN_BASE, 8'd0);
        check("tmo_err_cleared", 32'(err), 32'd0);
        wait_done("tmo_next_done", 20);
`else
        check("no_tmo_err", 32'(err), 32'd0);
`endif

        // Reset asserted while the second read beat is on the bus.
        tick();
        b_rise = rise_n;
        send_cmd(1'b0, 32'h3000_0400, 8'd3);
        for (int t = 0; t < 40 && (rise_n - b_rise) < 2; t++) tick();
        check("mid_cyc_up", 32'({cyc, busy}), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_drop", 32'({cyc, stb, busy}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        wr_vals[wr_idx & 63] = 32'h0000_0001;
        b_log = log_n;
        send_cmd(1'b1, C_SYN_BASE, 8'd1);
        wait_done("post_rst_done", 100);
        check("post_rst_beats", log_n - b_log, 32'd1);
        check("post_rst_adr", log_adr[b_log & 63], 32'h3000_000C);
        check("post_rst_dat", log_dat[b_log & 63], 32'h0000_0001);

        tick();
        check("bus_stb_sel", bus_bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
